mdu: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage. Accepts one M-extension op at a time from decode, computes it over multiple cycles and emits a one-cycle register-file write (data, address, enable) that drives the register file's write port. Decode stalls on `busy_o`; the exe/writeback mux selects this unit's write when `rd_wen_o` is high.

---
 rtl/mdu_if.sv | 23 ++
 rtl/mdu.sv | 201 ++++++++++++++++++++
 tb/tb_mdu.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_if.sv
// Decode/execute side handshake and register-file write port of the RV32M multiply/divide unit.
interface mdu_if;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        busy_o;
  logic [31:0] rd_data_o;
  logic [4:0]  rd_addr_o;
  logic        rd_wen_o;

  modport master (
    output start_i, op_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i,
    input  busy_o, rd_data_o, rd_addr_o, rd_wen_o
  );

  modport slave (
    input  start_i, op_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i,
    output busy_o, rd_data_o, rd_addr_o, rd_wen_o
  );
endinterface

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply, 32-step restoring divide.
// Defining MDU_FAST_MUL_EN replaces the iterative multiply with a single-cycle 64-bit multiply.
module mdu (
  input  logic  clk,
  input  logic  rst,
  mdu_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [4:0]  r_count;
  logic [4:0]  r_rdAddr;
  logic [4:0]  r_rdAddrOut;
  logic [31:0] r_rdData;
  logic        r_neg;
  logic        r_sel;
  logic [31:0] r_opB;
  logic [31:0] r_quot;
  logic [31:0] r_rem;

  logic        w_accept;
  logic        w_lastIter;
  logic        w_isDiv;
  logic        w_aSigned;
  logic        w_bSigned;
  logic        w_aNeg;
  logic        w_bNeg;
  logic [31:0] w_aMag;
  logic [31:0] w_bMag;
  logic        w_neg;
  logic        w_sel;
  logic        w_divZero;
  logic        w_divOvf;
  logic        w_special;
  logic [31:0] w_specialResult;

  logic [32:0] w_partial;
  logic [32:0] w_diff;
  logic        w_fits;
  logic [31:0] w_remNext;
  logic [31:0] w_quotNext;
  logic [31:0] w_divMag;
  logic [31:0] w_divResult;

  assign w_accept   = bus.start_i && (r_state == IDLE) && !bus.flush_i;
  assign w_lastIter = (r_count == 5'd31);

  // Operand conditioning on accept: magnitudes plus the sign the final result must carry.
  assign w_isDiv   = bus.op_i[2];
  assign w_aSigned = w_isDiv ? ~bus.op_i[0] : (bus.op_i[1:0] != 2'b11);
  assign w_bSigned = w_isDiv ? ~bus.op_i[0] : ~bus.op_i[1];
  assign w_aNeg    = w_aSigned & bus.rs1_data_i[31];
  assign w_bNeg    = w_bSigned & bus.rs2_data_i[31];
  assign w_aMag    = w_aNeg ? (32'd0 - bus.rs1_data_i) : bus.rs1_data_i;
  assign w_bMag    = w_bNeg ? (32'd0 - bus.rs2_data_i) : bus.rs2_data_i;
  assign w_neg     = (w_isDiv && bus.op_i[1]) ? w_aNeg : (w_aNeg ^ w_bNeg);
  assign w_sel     = w_isDiv ? bus.op_i[1] : (bus.op_i[1:0] != 2'b00);

  assign w_divZero = (bus.rs2_data_i == 32'd0);
  assign w_divOvf  = ~bus.op_i[0] && (bus.rs1_data_i == 32'h8000_0000) &&
                     (bus.rs2_data_i == 32'hFFFF_FFFF);
  assign w_special = w_isDiv && (w_divZero || w_divOvf);
  assign w_specialResult = w_divZero ? (bus.op_i[1] ? bus.rs1_data_i : 32'hFFFF_FFFF)
                                     : (bus.op_i[1] ? 32'd0 : 32'h8000_0000);

  // Restoring divide step: r_quot shifts the dividend out and the quotient bits in.
  assign w_partial   = {r_rem, r_quot[31]};
  assign w_diff      = w_partial - {1'b0, r_opB};
  assign w_fits      = ~w_diff[32];
  assign w_remNext   = w_fits ? w_diff[31:0] : w_partial[31:0];
  assign w_quotNext  = {r_quot[30:0], w_fits};
  assign w_divMag    = r_sel ? w_remNext : w_quotNext;
  assign w_divResult = r_neg ? (32'd0 - w_divMag) : w_divMag;

`ifdef MDU_FAST_MUL_EN
  logic [63:0] w_fastA;
  logic [63:0] w_fastB;
  logic [63:0] w_fastProd;
  logic [31:0] w_fastResult;

  assign w_fastA      = {{32{w_aNeg}}, bus.rs1_data_i};
  assign w_fastB      = {{32{w_bNeg}}, bus.rs2_data_i};
  assign w_fastProd   = w_fastA * w_fastB;
  assign w_fastResult = w_sel ? w_fastProd[63:32] : w_fastProd[31:0];
`else
  logic [63:0] r_prod;
  logic [32:0] w_addend;
  logic [32:0] w_sum;
  logic [63:0] w_prodNext;
  logic [63:0] w_prodSigned;
  logic [31:0] w_mulResult;

  // Shift-add step: the multiplier sits in the low half and is consumed one bit per cycle.
  assign w_addend     = r_prod[0] ? {1'b0, r_opB} : 33'd0;
  assign w_sum        = {1'b0, r_prod[63:32]} + w_addend;
  assign w_prodNext   = {w_sum, r_prod[31:1]};
  assign w_prodSigned = r_neg ? (64'd0 - w_prodNext) : w_prodNext;
  assign w_mulResult  = r_sel ? w_prodSigned[63:32] : w_prodSigned[31:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_isDiv) w_nextState = w_special ? DONE : DIV;
`ifdef MDU_FAST_MUL_EN
          else         w_nextState = DONE;
`else
          else         w_nextState = MUL;
`endif
        end
      end
`ifndef MDU_FAST_MUL_EN
      MUL:     if (w_lastIter) w_nextState = DONE;
`endif
      DIV:     if (w_lastIter) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
    if (bus.flush_i) w_nextState = IDLE;
  end

  // Result registers only move when a DONE is actually entered, so a flush leaves them untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= 5'd0;
      r_rdAddr    <= 5'd0;
      r_rdAddrOut <= 5'd0;
      r_rdData    <= 32'd0;
      r_neg       <= 1'b0;
      r_sel       <= 1'b0;
      r_opB       <= 32'd0;
      r_quot      <= 32'd0;
      r_rem       <= 32'd0;
`ifndef MDU_FAST_MUL_EN
      r_prod      <= 64'd0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_rdAddr <= bus.rd_addr_i;
            r_neg    <= w_neg;
            r_sel    <= w_sel;
            r_count  <= 5'd0;
            r_opB    <= w_bMag;
            r_quot   <= w_aMag;
            r_rem    <= 32'd0;
`ifndef MDU_FAST_MUL_EN
            r_prod   <= {32'd0, w_aMag};
`endif
            if (w_special) begin
              r_rdData    <= w_specialResult;
              r_rdAddrOut <= bus.rd_addr_i;
            end
`ifdef MDU_FAST_MUL_EN
            else if (!w_isDiv) begin
              r_rdData    <= w_fastResult;
              r_rdAddrOut <= bus.rd_addr_i;
            end
`endif
          end
        end
`ifndef MDU_FAST_MUL_EN
        MUL: begin
          r_prod  <= w_prodNext;
          r_count <= r_count + 5'd1;
          if (w_lastIter && !bus.flush_i) begin
            r_rdData    <= w_mulResult;
            r_rdAddrOut <= r_rdAddr;
          end
        end
`endif
        DIV: begin
          r_quot  <= w_quotNext;
          r_rem   <= w_remNext;
          r_count <= r_count + 5'd1;
          if (w_lastIter && !bus.flush_i) begin
            r_rdData    <= w_divResult;
            r_rdAddrOut <= r_rdAddr;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o    = (r_state != IDLE);
  assign bus.rd_wen_o  = (r_state == DONE) && (r_rdAddrOut != 5'd0);
  assign bus.rd_data_o = r_rdData;
  assign bus.rd_addr_o = r_rdAddrOut;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu; expected latencies follow MDU_FAST_MUL_EN when defined.
module tb_mdu;

  logic clk;
  logic rst;
  int   testsRun;
  int   testsFailed;

  mdu_if bus ();

  mdu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Presents one op for exactly one rising edge, then scrambles operands to prove they were latched.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd);
    @(negedge clk);
    bus.op_i       = op;
    bus.rs1_data_i = a;
    bus.rs2_data_i = b;
    bus.rd_addr_i  = rd;
    bus.start_i    = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i    = 1'b0;
    bus.rs1_data_i = $urandom;
    bus.rs2_data_i = $urandom;
    bus.rd_addr_i  = 5'd31;
  endtask

  task automatic observe(input int window, input int injectCyc, input int flushCyc,
                         output int firstCyc, output int nWrites, output logic [31:0] data,
                         output logic [4:0] addr, output logic [63:0] busyTrace);
    firstCyc  = 0;
    nWrites   = 0;
    data      = 'x;
    addr      = 'x;
    busyTrace = '0;
    for (int cyc = 1; cyc <= window; cyc++) begin
      @(negedge clk);
      busyTrace[cyc] = bus.busy_o;
      if (bus.rd_wen_o === 1'b1) begin
        if (nWrites == 0) begin
          firstCyc = cyc;
          data     = bus.rd_data_o;
          addr     = bus.rd_addr_o;
        end
        nWrites++;
      end
      if (cyc == injectCyc) begin
        bus.op_i       = 3'b011;
        bus.rs1_data_i = 32'h1234_5678;
        bus.rs2_data_i = 32'h0000_0003;
        bus.rd_addr_i  = 5'd8;
        bus.start_i    = 1'b1;
      end else if (cyc == injectCyc + 1) begin
        bus.start_i    = 1'b0;
      end
      if (cyc == flushCyc)          bus.flush_i = 1'b1;
      else if (cyc == flushCyc + 1) bus.flush_i = 1'b0;
    end
  endtask

  task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] expData,
                       input int expCyc);
    int          firstCyc;
    int          nWrites;
    logic [31:0] data;
    logic [4:0]  addr;
    logic [63:0] busyTrace;
    applyStimulus(op, a, b, rd);
    observe(40, 0, 0, firstCyc, nWrites, data, addr, busyTrace);
    checkOutput({tag, "_cycle"}, firstCyc, expCyc);
    checkOutput({tag, "_data"}, data, expData);
    checkOutput({tag, "_addr"}, {27'd0, addr}, {27'd0, rd});
    checkOutput({tag, "_writes"}, nWrites, 1);
    checkOutput({tag, "_busyDone"}, {31'd0, busyTrace[expCyc]}, 32'd1);
    checkOutput({tag, "_busyAfter"}, {31'd0, busyTrace[expCyc + 1]}, 32'd0);
  endtask

  initial begin
    int          firstCyc;
    int          nWrites;
    logic [31:0] data;
    logic [4:0]  addr;
    logic [63:0] busyTrace;
    int          earlyWrites;

    testsRun       = 0;
    testsFailed    = 0;
    rst            = 1'b1;
    bus.start_i    = 1'b0;
    bus.flush_i    = 1'b0;
    bus.op_i       = 3'b000;
    bus.rs1_data_i = 32'd0;
    bus.rs2_data_i = 32'd0;
    bus.rd_addr_i  = 5'd0;

    $display("[TB] reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    checkOutput("rst_wen", {31'd0, bus.rd_wen_o}, 32'd0);
    checkOutput("rst_data", bus.rd_data_o, 32'd0);
    checkOutput("rst_addr", {27'd0, bus.rd_addr_o}, 32'd0);
    rst = 1'b0;

    $display("[TB] multiply ops");
    runOp("mul",    3'b000, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, MUL_LAT);
    runOp("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, MUL_LAT);
    runOp("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFF, MUL_LAT);
    runOp("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFFE, MUL_LAT);

    $display("[TB] divide ops");
    runOp("div",  3'b100, 32'hFFFF_FFF9, 32'd2, 5'd12, 32'hFFFF_FFFD, DIV_LAT);
    runOp("rem",  3'b110, 32'hFFFF_FFF9, 32'd2, 5'd13, 32'hFFFF_FFFF, DIV_LAT);
    runOp("divu", 3'b101, 32'd100,       32'd7, 5'd14, 32'd14,        DIV_LAT);
    runOp("remu", 3'b111, 32'd100,       32'd7, 5'd15, 32'd2,         DIV_LAT);

    $display("[TB] special divides");
    runOp("div0",   3'b100, 32'd5,         32'd0,         5'd16, 32'hFFFF_FFFF, 1);
    runOp("rem0",   3'b110, 32'd5,         32'd0,         5'd17, 32'd5,         1);
    runOp("divOvf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, 1);
    runOp("remOvf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'd0,         1);

    $display("[TB] flush mid divide");
    applyStimulus(3'b100, 32'd1000, 32'd3, 5'd20);
    observe(40, 0, 10, firstCyc, nWrites, data, addr, busyTrace);
    checkOutput("flush_writes", nWrites, 0);
    checkOutput("flush_busyBefore", {31'd0, busyTrace[10]}, 32'd1);
    checkOutput("flush_busyAfter", {31'd0, busyTrace[11]}, 32'd0);

    $display("[TB] start while busy");
    applyStimulus(3'b101, 32'd100, 32'd7, 5'd7);
    observe(60, 5, 0, firstCyc, nWrites, data, addr, busyTrace);
    checkOutput("busyStart_cycle", firstCyc, 33);
    checkOutput("busyStart_data", data, 32'd14);
    checkOutput("busyStart_addr", {27'd0, addr}, 32'd7);
    checkOutput("busyStart_writes", nWrites, 1);
    checkOutput("busyStart_idle", {31'd0, busyTrace[34]}, 32'd0);

    $display("[TB] start with flush");
    @(negedge clk);
    bus.op_i       = 3'b100;
    bus.rs1_data_i = 32'd9;
    bus.rs2_data_i = 32'd0;
    bus.rd_addr_i  = 5'd3;
    bus.start_i    = 1'b1;
    bus.flush_i    = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i    = 1'b0;
    bus.flush_i    = 1'b0;
    observe(10, 0, 0, firstCyc, nWrites, data, addr, busyTrace);
    checkOutput("startFlush_busy", {31'd0, busyTrace[1]}, 32'd0);
    checkOutput("startFlush_writes", nWrites, 0);

    $display("[TB] rd zero");
    applyStimulus(3'b101, 32'd100, 32'd7, 5'd0);
    observe(40, 0, 0, firstCyc, nWrites, data, addr, busyTrace);
    checkOutput("rd0_writes", nWrites, 0);
    checkOutput("rd0_busyDone", {31'd0, busyTrace[33]}, 32'd1);
    checkOutput("rd0_busyIdle", {31'd0, busyTrace[34]}, 32'd0);

    $display("[TB] reset mid multiply");
    runOp("preRst", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd21, 32'hFFFF_FFFE, MUL_LAT);
    applyStimulus(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
    earlyWrites = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (bus.rd_wen_o === 1'b1) earlyWrites++;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midRst_busy", {31'd0, bus.busy_o}, 32'd0);
    checkOutput("midRst_wen", {31'd0, bus.rd_wen_o}, 32'd0);
    checkOutput("midRst_data", bus.rd_data_o, 32'd0);
    checkOutput("midRst_addr", {27'd0, bus.rd_addr_o}, 32'd0);
`ifndef MDU_FAST_MUL_EN
    checkOutput("midRst_noWrite", earlyWrites, 0);
`endif
    rst            = 1'b0;
    bus.op_i       = 3'b100;
    bus.rs1_data_i = 32'd5;
    bus.rs2_data_i = 32'd0;
    bus.rd_addr_i  = 5'd4;
    bus.start_i    = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i    = 1'b0;
    observe(10, 0, 0, firstCyc, nWrites, data, addr, busyTrace);
    checkOutput("postRst_cycle", firstCyc, 1);
    checkOutput("postRst_data", data, 32'hFFFF_FFFF);
    checkOutput("postRst_addr", {27'd0, addr}, 32'd4);
    checkOutput("postRst_writes", nWrites, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
